// File: rtl/mo_mul_sched.sv
// mo_mul_sched
// Round-robin scheduler sharing one pipelined mo_mul between N_REQ requesters.
// One operand pair is accepted per cycle (valid/ready). The accepted pair is
// registered onto mul_a/mul_b, and the requester ID travels down a valid/ID
// shift line that matches the mo_mul latency. When the line tail is valid,
// mul_c is steered back to the owning requester.
//
// Optional feature: define MO_MUL_SCHED_PERF_EN to add the perf_clr input and
// the perf_issued/perf_stall counters.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active-high
//   req_valid   per-requester operand valid
//   req_ready   per-requester grant, one-hot or zero
//   req_a/b     packed operands, requester i at [i*DW +: DW]
//   hold        1 = issue no new grants (in-flight ops still complete)
//   mul_a/b     registered operands to mo_mul
//   mul_c       mo_mul result
//   resp_valid  one-hot result strobe to the owning requester
//   resp_data   result bus, 0 when no result is presented
//   busy        1 while any op is in the valid line
//   perf_clr    (perf build) clear both counters
//   perf_issued (perf build) grants issued, wraps at 2^32
//   perf_stall  (perf build) cycles with any request pending but no grant
module mo_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int MUL_LAT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  input  logic                hold,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  input  logic [DW-1:0]       mul_c,
  output logic [N_REQ-1:0]    resp_valid,
  output logic [DW-1:0]       resp_data,
  output logic                busy
`ifdef MO_MUL_SCHED_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall
`endif
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]               rr_ptr;
  logic [IDW-1:0]               grant_id;
  logic [IDW-1:0]               idx;
  logic                         found;
  logic                         grant;
  logic [DW-1:0]                a_sel;
  logic [DW-1:0]                b_sel;
  logic [MUL_LAT:0]             line_vld;
  logic [MUL_LAT:0][IDW-1:0]    line_id;
  logic                         tail_vld;

  // Search starts just past the last granted requester, so the winner of
  // this cycle drops to lowest priority next cycle.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = IDW'((int'(rr_ptr) + off) % N_REQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    grant     = found && !hold && !rst;
    req_ready = grant ? (N_REQ'(1) << grant_id) : '0;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        a_sel = req_a[i*DW +: DW];
        b_sel = req_b[i*DW +: DW];
      end
    end
  end

  // The line never stalls: a bubble is shifted in on every non-grant cycle,
  // which keeps it aligned with the free-running mo_mul pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= IDW'(N_REQ - 1);
      mul_a    <= '0;
      mul_b    <= '0;
      line_vld <= '0;
      line_id  <= '0;
    end else begin
      line_vld <= {line_vld[MUL_LAT-1:0], grant};
      line_id  <= {line_id[MUL_LAT-1:0], grant_id};
      if (grant) begin
        mul_a  <= a_sel;
        mul_b  <= b_sel;
        rr_ptr <= grant_id;
      end
    end
  end

  // Outputs are forced quiet during reset so a flushed op never leaks out in
  // the reset cycle itself.
  always_comb begin
    tail_vld   = line_vld[MUL_LAT] && !rst;
    resp_valid = tail_vld ? (N_REQ'(1) << line_id[MUL_LAT]) : '0;
    resp_data  = tail_vld ? mul_c : '0;
    busy       = (|line_vld) && !rst;
  end

`ifdef MO_MUL_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if ((|req_valid) && !grant) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
